// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS-subset control sequencer:
// states, opcodes, datapath select encodings and decoder bundles.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    R_WB     = 4'd3,
    EXEC_I   = 4'd4,
    I_WB     = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WB   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JAL      = 4'd12,
    TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_ITYPE = 2'd3;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  typedef struct packed {
    logic zext;
    logic is_lw;
    logic is_bne;
  } cls_t;

  typedef struct packed {
    state_t nxt;
    cls_t   cls;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Opcode decoder: picks the post-DECODE state and the
// instruction class bits held for the later phases.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  output dec_t           dec
);

  always_comb begin
    dec = '{nxt: TRAP, cls: '0};
    unique case (1'b1)
      (opcode == OP_RTYPE): dec.nxt = EXEC_R;
      (opcode == OP_LW): begin
        dec.nxt = MEM_ADDR;
        dec.cls.is_lw = 1'b1;
      end
      (opcode == OP_SW): dec.nxt = MEM_ADDR;
      (opcode == OP_BEQ): dec.nxt = BRANCH;
      (opcode == OP_BNE): begin
        dec.nxt = BRANCH;
        dec.cls.is_bne = 1'b1;
      end
      (opcode == OP_ADDI),
      (opcode == OP_SLTI): dec.nxt = EXEC_I;
      (opcode == OP_ANDI),
      (opcode == OP_ORI),
      (opcode == OP_XORI): begin
        dec.nxt = EXEC_I;
        dec.cls.zext = 1'b1;
      end
      (opcode == OP_J): dec.nxt = JUMP;
      (opcode == OP_JAL): dec.nxt = JAL;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer. Optional perf counters are
// enabled with `define MC_CTRL_PERF_CNT_EN.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_beq,
  output logic           pc_write_bne,
  output logic           iord,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic [1:0]     reg_dst,
  output logic [1:0]     mem_to_reg,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic           ext_op,
  output logic           illegal,
  output logic [STW-1:0] state
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]    cycle_cnt,
  output logic [31:0]    instr_cnt
`endif
);

  state_t st, nxt;
  dec_t   dec;
  cls_t   cls;
  logic   ill_q;

  mc_ctrl_decode #(.OPW(OPW)) u_dec (
    .opcode(opcode),
    .dec   (dec)
  );

  always_comb begin
    nxt = FETCH;
    unique case (st)
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE:   nxt = dec.nxt;
      EXEC_R:   nxt = R_WB;
      EXEC_I:   nxt = I_WB;
      MEM_ADDR: nxt = cls.is_lw ? MEM_RD : MEM_WR;
      MEM_RD:   nxt = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   nxt = mem_ready ? FETCH : MEM_WR;
      TRAP:     nxt = TRAP;
      default:  nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= FETCH;
      cls   <= '0;
      ill_q <= 1'b0;
    end else begin
      st <= nxt;
      if (st == DECODE) cls <= dec.cls;
      if (nxt == TRAP) ill_q <= 1'b1;
    end
  end

  // Reset forces the idle vector so an aborted instruction emits nothing.
  always_comb begin
    pc_write     = 1'b0;
    pc_write_beq = 1'b0;
    pc_write_bne = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_dst      = RDST_RT;
    mem_to_reg   = M2R_ALU;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_B;
    alu_op       = ALU_ADD;
    pc_source    = PCS_ALU;
    ext_op       = 1'b1;
    if (!rst) begin
      unique case (st)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: alu_src_b = SRCB_IMM_SH;
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        R_WB: begin
          reg_dst   = RDST_RD;
          reg_write = 1'b1;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_ITYPE;
          ext_op    = ~cls.zext;
        end
        I_WB: reg_write = 1'b1;
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEM_WB: begin
          mem_to_reg = M2R_MDR;
          reg_write  = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        BRANCH: begin
          alu_src_a    = 1'b1;
          alu_op       = ALU_SUB;
          pc_source    = PCS_ALUOUT;
          pc_write_beq = ~cls.is_bne;
          pc_write_bne = cls.is_bne;
        end
        JUMP: begin
          pc_source = PCS_JUMP;
          pc_write  = 1'b1;
        end
        JAL: begin
          pc_source  = PCS_JUMP;
          pc_write   = 1'b1;
          reg_dst    = RDST_RA;
          mem_to_reg = M2R_PC;
          reg_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal = ill_q & ~rst;
  assign state   = STW'(st);

`ifdef MC_CTRL_PERF_CNT_EN
  logic done;

  always_comb begin
    done = (nxt == FETCH) &&
           (st inside {R_WB, I_WB, MEM_WB, MEM_WR,
                       BRANCH, JUMP, JAL});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (done) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction expected control
// vectors built from opcode, stall counts and random fill.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic       pcw;
    logic       beq;
    logic       bne;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       rw;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] aop;
    logic [1:0] psrc;
    logic       ext;
    logic       ill;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;

  logic       pc_write, pc_write_beq, pc_write_bne;
  logic       iord, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       ext_op, illegal;
  logic [3:0] state;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
  logic [31:0] ecyc = 32'd0;
  logic [31:0] einst = 32'd0;
`endif

  int errors = 0;
  int checks = 0;
  ctl_t obs;

  always #5 clk = ~clk;

  mc_control_fsm #(.OPW(6), .STW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .pc_write_beq(pc_write_beq),
    .pc_write_bne(pc_write_bne),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .pc_source   (pc_source),
    .ext_op      (ext_op),
    .illegal     (illegal),
    .state       (state)
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt)
`endif
  );

  assign obs = {pc_write, pc_write_beq, pc_write_bne, iord,
                mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b,
                alu_op, pc_source, ext_op, illegal};

  function automatic ctl_t idle();
    ctl_t v = '0;
    v.ext = 1'b1;
    return v;
  endfunction

  function automatic ctl_t fetch(input bit r);
    ctl_t v = idle();
    v.mrd = 1'b1;
    v.sb  = 2'd1;
    v.irw = r;
    v.pcw = r;
    return v;
  endfunction

  task automatic step(input ctl_t e, input logic [5:0] op,
                      input bit rdy, input bit done,
                      input bit r, input string tag);
    @(negedge clk);
    rst = r;
    opcode = op;
    mem_ready = rdy;
    #1;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: ctl got %h want %h", tag, obs, e);
    end
`ifdef MC_CTRL_PERF_CNT_EN
    checks++;
    assert (cycle_cnt === ecyc) else begin
      errors++;
      $error("FAIL %s_cyc: got %0d want %0d", tag, cycle_cnt, ecyc);
    end
    checks++;
    assert (instr_cnt === einst) else begin
      errors++;
      $error("FAIL %s_ins: got %0d want %0d", tag, instr_cnt, einst);
    end
    if (r) begin
      ecyc = 32'd0;
      einst = 32'd0;
    end else begin
      ecyc++;
      if (done) einst++;
    end
`endif
  endtask

  task automatic chk_state(input logic [3:0] e, input string tag);
    checks++;
    assert (state === e) else begin
      errors++;
      $error("FAIL %s_state: got %0d want %0d", tag, state, e);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fs,
                           input int ms, input string tag);
    ctl_t q[$];
    bit   rq[$];
    ctl_t v;
    bit   trap = 1'b0;
    for (int i = 0; i < fs; i++) begin
      q.push_back(fetch(1'b0));
      rq.push_back(1'b0);
    end
    q.push_back(fetch(1'b1));
    rq.push_back(1'b1);
    v = idle();
    v.sb = 2'd3;
    q.push_back(v);
    rq.push_back(1'($urandom));
    case (op)
      6'h00: begin
        v = idle(); v.sa = 1; v.aop = 2'd2;
        q.push_back(v); rq.push_back(1'($urandom));
        v = idle(); v.rdst = 2'd1; v.rw = 1;
        q.push_back(v); rq.push_back(1'($urandom));
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
        v = idle(); v.sa = 1; v.sb = 2'd2; v.aop = 2'd3;
        v.ext = !(op >= 6'h0C && op <= 6'h0E);
        q.push_back(v); rq.push_back(1'($urandom));
        v = idle(); v.rw = 1;
        q.push_back(v); rq.push_back(1'($urandom));
      end
      6'h23, 6'h2B: begin
        v = idle(); v.sa = 1; v.sb = 2'd2;
        q.push_back(v); rq.push_back(1'($urandom));
        v = idle(); v.iord = 1;
        if (op == 6'h23) v.mrd = 1;
        else v.mwr = 1;
        for (int i = 0; i < ms; i++) begin
          q.push_back(v); rq.push_back(1'b0);
        end
        q.push_back(v); rq.push_back(1'b1);
        if (op == 6'h23) begin
          v = idle(); v.m2r = 2'd1; v.rw = 1;
          q.push_back(v); rq.push_back(1'($urandom));
        end
      end
      6'h04, 6'h05: begin
        v = idle(); v.sa = 1; v.aop = 2'd1; v.psrc = 2'd1;
        v.beq = (op == 6'h04);
        v.bne = (op == 6'h05);
        q.push_back(v); rq.push_back(1'($urandom));
      end
      6'h02, 6'h03: begin
        v = idle(); v.psrc = 2'd2; v.pcw = 1;
        if (op == 6'h03) begin
          v.rdst = 2'd2; v.m2r = 2'd2; v.rw = 1;
        end
        q.push_back(v); rq.push_back(1'($urandom));
      end
      default: begin
        trap = 1'b1;
        v = idle(); v.ill = 1;
        for (int i = 0; i < 20; i++) begin
          q.push_back(v); rq.push_back(1'($urandom));
        end
      end
    endcase
    for (int i = 0; i < q.size(); i++) begin
      step(q[i], (i == fs + 1) ? op : 6'($urandom), rq[i],
           !trap && (i == q.size() - 1), 1'b0, tag);
      if (i == 0) chk_state(FETCH, tag);
    end
  endtask

  logic [5:0] legal [12] = '{6'h00, 6'h23, 6'h2B, 6'h04,
                             6'h05, 6'h08, 6'h0A, 6'h0C,
                             6'h0D, 6'h0E, 6'h02, 6'h03};

  initial begin
    ctl_t v;
    step(idle(), 6'h00, 1'b1, 1'b0, 1'b1, "reset0");
    chk_state(FETCH, "reset0");
    step(idle(), 6'h00, 1'b1, 1'b0, 1'b1, "reset1");
    chk_state(FETCH, "reset1");

    run_instr(6'h00, 0, 0, "rtype");
    run_instr(6'h23, 0, 3, "lw_stall");
    run_instr(6'h0C, 0, 0, "andi");
    run_instr(6'h08, 0, 0, "addi");
    run_instr(6'h04, 0, 0, "beq");
    run_instr(6'h05, 0, 0, "bne");
    run_instr(6'h03, 0, 0, "jal");
    run_instr(6'h02, 2, 0, "j_fstall");
    run_instr(6'h2B, 1, 2, "sw_stall");
    run_instr(6'h0E, 0, 0, "xori");
    run_instr(6'h0A, 0, 0, "slti");

    for (int k = 0; k < 30; k++) begin
      run_instr(legal[$urandom_range(0, 11)],
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), "rand");
    end

    // abort a load partway through
    step(fetch(1'b1), 6'h23, 1'b1, 1'b0, 1'b0, "abort_f");
    v = idle(); v.sb = 2'd3;
    step(v, 6'h23, 1'b1, 1'b0, 1'b0, "abort_d");
    v = idle(); v.sa = 1; v.sb = 2'd2;
    step(v, 6'h00, 1'b0, 1'b0, 1'b0, "abort_a");
    step(idle(), 6'h00, 1'b1, 1'b0, 1'b1, "abort_r0");
    step(idle(), 6'h00, 1'b1, 1'b0, 1'b1, "abort_r1");
    chk_state(FETCH, "abort_r1");
    run_instr(6'h00, 0, 0, "post_abort");

    run_instr(6'h3F, 1, 0, "trap");
    step(idle(), 6'h00, 1'b1, 1'b0, 1'b1, "trap_r0");
    step(idle(), 6'h00, 1'b1, 1'b0, 1'b1, "trap_r1");
    chk_state(FETCH, "trap_r1");
    run_instr(6'h00, 0, 0, "post_trap");
    run_instr(6'h23, 0, 0, "post_trap_lw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control sequencer for the MIPS-subset datapath: decodes IR opcode and steps through FETCH/DECODE/EXEC/MEM/WB, driving every datapath select, write-enable and the immediate-extender mode (ext_op).
- Sits between the instruction register and the shared ALU/memory/register-file datapath.
- Stalls on a ready handshake from the unified instruction/data memory.

Parameters:
- OPW, 6, opcode field width (IR[31:26])
- STW, 4, state register width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  OPW  IR[31:26]
- mem_ready  in  1  memory handshake; access completes in a cycle where mem_read|mem_write and mem_ready are both 1
- pc_write  out  1  unconditional PC load
- pc_write_beq  out  1  PC load if ALU zero
- pc_write_bne  out  1  PC load if ALU not zero
- iord  out  1  0=PC address, 1=ALUOut address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC
- reg_write  out  1  register-file write
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  0=B, 1=const 4, 2=ext(imm), 3=ext(imm)<<2
- alu_op  out  2  0=add, 1=sub, 2=funct-decode, 3=opcode-decode (I-type)
- pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target
- ext_op  out  1  1=sign-extend imm16, 0=zero-extend
- illegal  out  1  sticky illegal-opcode flag
- state  out  STW  current state (debug)

Behaviour:
- Moore FSM; outputs decoded from state (plus registered opcode class); one state per cycle unless stalled.
- Reset: state=FETCH; illegal=0. In reset cycle all strobes (pc_write, pc_write_beq/bne, mem_read, mem_write, ir_write, reg_write) are 0; all selects are 0; ext_op=1. Reset mid-instruction aborts it with no further strobes.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0. While mem_ready=0, hold FETCH with ir_write=0 and pc_write=0. In the mem_ready=1 cycle, assert ir_write=1 and pc_write=1, then go to DECODE. PC+4 and IR update together exactly once.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0, ext_op=1 (branch target precompute). Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x23/0x2B -> MEM_ADDR
  - 0x04/0x05 -> BRANCH
  - 0x08,0x0A,0x0C,0x0D,0x0E -> EXEC_I
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - other -> TRAP
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2 -> R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=3; ext_op=0 for andi/ori/xori (0x0C-0x0E), 1 for addi/slti -> I_WB.
- I_WB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0, ext_op=1 -> MEM_RD (0x23) or MEM_WR (0x2B).
- MEM_RD: mem_read=1, iord=1; hold until mem_ready -> MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEM_WR: mem_write=1, iord=1; hold until mem_ready -> FETCH. Exactly one write acknowledge per instruction.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1; pc_write_beq=1 if 0x04, pc_write_bne=1 if 0x05 -> FETCH.
- JUMP: pc_source=2, pc_write=1 -> FETCH.
- JAL: pc_source=2, pc_write=1, reg_dst=2, mem_to_reg=2, reg_write=1 -> FETCH. The register file captures the old PC+4 on the same edge.
- TRAP: illegal=1; all strobes 0; stays in TRAP until rst.
- Opcode is sampled only in DECODE and held in a class register; IR changes outside FETCH do not alter the path.
- Cycle counts with mem_ready held at 1: R/I=4, lw=5, sw=4, beq/bne=3, j/jal=3.
- Unused state encodings -> FETCH next cycle, no strobes.

Optional Feature:
- Macro: MC_CTRL_PERF_CNT_EN.
- Defined:
  - Adds output ports cycle_cnt (32) and instr_cnt (32), both reset to 0.
  - cycle_cnt increments every non-reset cycle, including stalls and TRAP.
  - instr_cnt increments on each transition into FETCH from a final state.
  - Both wrap modulo 2^32.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package mc_ctrl_pkg: state localparams (FETCH..TRAP), opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_J, OP_JAL), alu_op/alu_src_b/pc_source/reg_dst/mem_to_reg encodings.
- Sub-module: mc_ctrl_decode, a combinational opcode -> next-state/ext_op class decoder. State register and output decode stay in the top.

Test Plan:
- rst=1 for 2 cycles, then release with opcode=0x00, mem_ready=1: state=FETCH during reset with all strobes 0; ir_write and pc_write pulse in cycle 1 after release; reg_write=1, reg_dst=1 in cycle 4.
- lw (0x23) with mem_ready low 3 cycles in MEM_RD: mem_read/iord held 4 cycles, MEM_WB follows once, reg_write=1 with mem_to_reg=1; total 8 cycles.
- andi 0x0C vs addi 0x08: ext_op=0 in EXEC_I for andi, 1 for addi; alu_src_b=2 in both.
- beq 0x04 then bne 0x05: only pc_write_beq=1 (resp. only pc_write_bne=1) in BRANCH, alu_op=1, pc_source=1; next state FETCH.
- jal 0x03: JAL cycle shows pc_write=1, reg_dst=2, mem_to_reg=2, reg_write=1; 3 cycles total.
- opcode 0x3F: TRAP entered after DECODE, illegal=1 sticky, no strobes for 20 cycles; rst returns to FETCH with illegal=0. With MC_CTRL_PERF_CNT_EN defined, instr_cnt does not advance while in TRAP.
